// File: rtl/alu_pkg.sv
// Shared function codes and FSM state type for the multi-cycle ALU.
package alu_pkg;

   localparam logic [3:0] FN_ADD  = 4'b0000;
   localparam logic [3:0] FN_SUB  = 4'b0001;
   localparam logic [3:0] FN_AND  = 4'b0010;
   localparam logic [3:0] FN_OR   = 4'b0011;
   localparam logic [3:0] FN_XOR  = 4'b0100;
   localparam logic [3:0] FN_SHL1 = 4'b0101;
   localparam logic [3:0] FN_SHR1 = 4'b0110;
   localparam logic [3:0] FN_NOT  = 4'b0111;
   localparam logic [3:0] FN_PASS = 4'b1000;
   localparam logic [3:0] FN_MUL  = 4'b1001;
   localparam logic [3:0] FN_SHLN = 4'b1010;
   localparam logic [3:0] FN_SHRN = 4'b1011;
   localparam logic [3:0] FN_SARN = 4'b1100;

   typedef enum logic [2:0] {IDLE, EXEC, MUL, SHIFT, DONE} state_e;

   function automatic logic is_shift(input logic [3:0] func);
      return (func == FN_SHLN) || (func == FN_SHRN) || (func == FN_SARN);
   endfunction

endpackage

// File: rtl/alu_comb_core.sv
// Combinational single-cycle ALU functions with C/Z/V/S flags.
module alu_comb_core
   import alu_pkg::*;
#(
   parameter int unsigned WIDTH = 16
) (
   input  logic [3:0]       func,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic [WIDTH-1:0] res,
   output logic             c,
   output logic             z,
   output logic             v,
   output logic             s
);

   logic [WIDTH:0] sum;
   logic           known;

   always_comb begin
      res   = '0;
      c     = 1'b0;
      v     = 1'b0;
      known = 1'b1;
      sum   = '0;
      case (func)
         FN_ADD: begin
            sum = {1'b0, b} + {1'b0, a} + {{WIDTH{1'b0}}, cin};
            res = sum[WIDTH-1:0];
            c   = sum[WIDTH];
            v   = (a[WIDTH-1] == b[WIDTH-1]) && (res[WIDTH-1] != a[WIDTH-1]);
         end
         FN_SUB: begin
            // A negative WIDTH+1-bit difference sets the top bit: that is the borrow.
            sum = {1'b0, b} - {1'b0, a} - {{WIDTH{1'b0}}, cin};
            res = sum[WIDTH-1:0];
            c   = sum[WIDTH];
            v   = (a[WIDTH-1] != b[WIDTH-1]) && (res[WIDTH-1] != b[WIDTH-1]);
         end
         FN_AND:  res = a & b;
         FN_OR:   res = a | b;
         FN_XOR:  res = a ^ b;
         FN_SHL1: begin
            res = {b[WIDTH-2:0], 1'b0};
            c   = b[WIDTH-1];
         end
         FN_SHR1: begin
            res = {1'b0, b[WIDTH-1:1]};
            c   = b[0];
         end
         FN_NOT:  res = ~b;
         FN_PASS: res = b;
         default: known = 1'b0;
      endcase
      z = known && (res == '0);
      s = res[WIDTH-1];
   end

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle handshaked ALU: single-cycle ops via alu_comb_core, iterative
// shift-add multiply and one-bit-per-cycle multi-bit shifts.
module alu_mc
   import alu_pkg::*;
#(
   parameter int unsigned WIDTH = 16,
   parameter int unsigned SHW   = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [3:0]       alu_func,
   input  logic [WIDTH-1:0] alu_a,
   input  logic [WIDTH-1:0] alu_b,
   input  logic             cin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] alu_out,
   output logic             c,
   output logic             z,
   output logic             v,
   output logic             s
);

   localparam logic [SHW:0] MUL_ITERS = WIDTH[SHW:0];

   state_e             state_q;
   logic [3:0]         func_q;
   logic [WIDTH-1:0]   a_q;
   logic [WIDTH-1:0]   b_q;
   logic               cin_q;
   logic [2*WIDTH-1:0] acc_q;
   logic [2*WIDTH-1:0] mcand_q;
   logic [SHW:0]       cnt_q;
   logic               sh_c_q;

   logic [WIDTH-1:0]   core_res;
   logic               core_c, core_z, core_v, core_s;
   logic [WIDTH-1:0]   fin_res;
   logic               fin_c, fin_z, fin_v, fin_s;
   logic [SHW-1:0]     n_in;

   assign n_in      = alu_a[SHW-1:0];
   assign in_ready  = (state_q == IDLE);
   assign out_valid = (state_q == DONE);

   alu_comb_core #(
      .WIDTH (WIDTH)
   ) u_core (
      .func (func_q),
      .a    (a_q),
      .b    (b_q),
      .cin  (cin_q),
      .res  (core_res),
      .c    (core_c),
      .z    (core_z),
      .v    (core_v),
      .s    (core_s)
   );

   // Result selection for the cycle that enters DONE; b_q doubles as the shift register.
   always_comb begin
      fin_res = core_res;
      fin_c   = core_c;
      fin_z   = core_z;
      fin_v   = core_v;
      fin_s   = core_s;
      if (state_q == MUL) begin
         fin_res = acc_q[WIDTH-1:0];
         fin_c   = |acc_q[2*WIDTH-1:WIDTH];
         fin_v   = fin_c;
         fin_z   = (fin_res == '0);
         fin_s   = fin_res[WIDTH-1];
      end else if (is_shift(func_q)) begin
         fin_res = b_q;
         fin_c   = sh_c_q;
         fin_v   = 1'b0;
         fin_z   = (fin_res == '0);
         fin_s   = fin_res[WIDTH-1];
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         func_q  <= '0;
         a_q     <= '0;
         b_q     <= '0;
         cin_q   <= 1'b0;
         acc_q   <= '0;
         mcand_q <= '0;
         cnt_q   <= '0;
         sh_c_q  <= 1'b0;
         alu_out <= '0;
         c       <= 1'b0;
         z       <= 1'b0;
         v       <= 1'b0;
         s       <= 1'b0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (in_valid) begin
                  func_q  <= alu_func;
                  a_q     <= alu_a;
                  b_q     <= alu_b;
                  cin_q   <= cin;
                  acc_q   <= '0;
                  mcand_q <= {{WIDTH{1'b0}}, alu_a};
                  sh_c_q  <= 1'b0;
                  cnt_q   <= is_shift(alu_func) ? {1'b0, n_in} : '0;
                  if (alu_func == FN_MUL)
                     state_q <= MUL;
                  else if (is_shift(alu_func) && (n_in != '0))
                     state_q <= SHIFT;
                  else
                     state_q <= EXEC;
               end
            end
            EXEC: begin
               state_q <= DONE;
               alu_out <= fin_res;
               c       <= fin_c;
               z       <= fin_z;
               v       <= fin_v;
               s       <= fin_s;
            end
            MUL: begin
               if (cnt_q == MUL_ITERS) begin
                  state_q <= DONE;
                  alu_out <= fin_res;
                  c       <= fin_c;
                  z       <= fin_z;
                  v       <= fin_v;
                  s       <= fin_s;
               end else begin
                  if (b_q[0]) acc_q <= acc_q + mcand_q;
                  mcand_q <= {mcand_q[2*WIDTH-2:0], 1'b0};
                  b_q     <= {1'b0, b_q[WIDTH-1:1]};
                  cnt_q   <= cnt_q + 1'b1;
               end
            end
            SHIFT: begin
               if (cnt_q == '0) begin
                  state_q <= DONE;
                  alu_out <= fin_res;
                  c       <= fin_c;
                  z       <= fin_z;
                  v       <= fin_v;
                  s       <= fin_s;
               end else begin
                  case (func_q)
                     FN_SHLN: {sh_c_q, b_q} <= {b_q, 1'b0};
                     FN_SHRN: {b_q, sh_c_q} <= {1'b0, b_q};
                     default: {b_q, sh_c_q} <= {b_q[WIDTH-1], b_q};
                  endcase
                  cnt_q <= cnt_q - 1'b1;
               end
            end
            DONE: begin
               if (out_ready) state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_mc.sv
// Self-checking bench for alu_mc: directed cases, backpressure, reset abort and
// randomized operations against an arithmetic reference model.
module tb_alu_mc;

   localparam int W = 16;

   logic          clk = 1'b0;
   logic          reset;
   logic          in_valid;
   logic          in_ready;
   logic [3:0]    alu_func;
   logic [W-1:0]  alu_a;
   logic [W-1:0]  alu_b;
   logic          cin;
   logic          out_valid;
   logic          out_ready;
   logic [W-1:0]  alu_out;
   logic          c, z, v, s;

   int checks   = 0;
   int failures = 0;

   alu_mc #(
      .WIDTH (W)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .alu_func  (alu_func),
      .alu_a     (alu_a),
      .alu_b     (alu_b),
      .cin       (cin),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .alu_out   (alu_out),
      .c         (c),
      .z         (z),
      .v         (v),
      .s         (s)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp)
      else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
      end
   endtask

   // Reference model: plain integer arithmetic on the function definitions.
   task automatic ref_model(input logic [3:0] f, input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic ci, output logic [W-1:0] res, output logic [3:0] czvs,
                            output int lat);
      longint unsigned p;
      longint          sv;
      int              n;
      logic            rc, rv, known;
      n     = int'(a[3:0]);
      rc    = 1'b0;
      rv    = 1'b0;
      known = 1'b1;
      lat   = 1;
      res   = '0;
      case (f)
         4'h0: begin
            p   = longint'(b) + longint'(a) + longint'(ci);
            res = p[W-1:0];
            rc  = (p >= 64'h10000);
            sv  = longint'($signed(b)) + longint'($signed(a)) + longint'(ci);
            rv  = (sv > 32767) || (sv < -32768);
         end
         4'h1: begin
            res = b - a - W'(ci);
            rc  = (longint'(b) < longint'(a) + longint'(ci));
            sv  = longint'($signed(b)) - longint'($signed(a)) - longint'(ci);
            rv  = (sv > 32767) || (sv < -32768);
         end
         4'h2: res = a & b;
         4'h3: res = a | b;
         4'h4: res = a ^ b;
         4'h5: begin res = b << 1; rc = b[W-1]; end
         4'h6: begin res = b >> 1; rc = b[0]; end
         4'h7: res = ~b;
         4'h8: res = b;
         4'h9: begin
            p   = longint'(a) * longint'(b);
            res = p[W-1:0];
            rc  = (p >> W) != 0;
            rv  = rc;
            lat = W + 1;
         end
         4'hA: begin
            res = b << n;
            rc  = (n != 0) ? b[W-n] : 1'b0;
            lat = n + 1;
         end
         4'hB, 4'hC: begin
            res = (f == 4'hB) ? (b >> n) : W'($signed(b) >>> n);
            rc  = (n != 0) ? b[n-1] : 1'b0;
            lat = n + 1;
         end
         default: known = 1'b0;
      endcase
      czvs = {rc, known && (res == '0), rv, res[W-1]};
   endtask

   // Issue one op, measure latency from the accept edge, check result, then leave DONE.
   task automatic do_op(input string tag, input logic [3:0] f, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic ci);
      logic [W-1:0] er;
      logic [3:0]   ef;
      int           elat, lat;
      ref_model(f, a, b, ci, er, ef, elat);
      @(negedge clk);
      in_valid = 1'b1;
      alu_func = f;
      alu_a    = a;
      alu_b    = b;
      cin      = ci;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      alu_func = 4'($urandom);
      alu_a    = W'($urandom);
      alu_b    = W'($urandom);
      cin      = 1'($urandom);
      chk({tag, ".in_ready_busy"}, 32'(in_ready), 32'(elat == 1 ? 1'b0 : 1'b0));
      lat = 0;
      for (int i = 1; i <= 40; i++) begin
         if (i > 1) begin
            @(posedge clk);
            #1;
         end else begin
            @(posedge clk);
            #1;
         end
         if (out_valid) begin
            lat = i;
            break;
         end
      end
      chk({tag, ".latency"}, 32'(lat), 32'(elat));
      chk({tag, ".alu_out"}, 32'(alu_out), 32'(er));
      chk({tag, ".czvs"}, 32'({c, z, v, s}), 32'(ef));
      @(posedge clk);
      #1;
      chk({tag, ".idle_after"}, 32'({in_ready, out_valid}), 32'(2'b10));
   endtask

   initial begin
      logic [W-1:0] held;
      logic         seen;
      reset     = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      alu_func  = '0;
      alu_a     = '0;
      alu_b     = '0;
      cin       = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      chk("reset.flags", 32'({in_ready, out_valid, c, z, v, s}), 32'(6'b100000));
      chk("reset.alu_out", 32'(alu_out), 32'h0);

      do_op("add_ovf", 4'h0, 16'h7FFF, 16'h0001, 1'b0);
      do_op("sub_borrow", 4'h1, 16'h0000, 16'h0000, 1'b1);
      do_op("sub_ovf", 4'h1, 16'h0001, 16'h8000, 1'b0);
      do_op("mul_wrap", 4'h9, 16'h0100, 16'h0100, 1'b0);
      do_op("mul_small", 4'h9, 16'h0003, 16'h0005, 1'b0);
      do_op("shln4", 4'hA, 16'h0004, 16'h0001, 1'b0);
      do_op("sarn1", 4'hC, 16'h0001, 16'h8001, 1'b0);
      do_op("shrn0", 4'hB, 16'hFFF0, 16'hA5A5, 1'b0);
      do_op("shln15", 4'hA, 16'h000F, 16'h0003, 1'b0);
      do_op("unused_fn", 4'hE, 16'h1234, 16'h5678, 1'b1);

      // Backpressure: DONE must hold and ignore new requests.
      out_ready = 1'b0;
      @(negedge clk);
      in_valid = 1'b1;
      alu_func = 4'h2;
      alu_a    = 16'hF0F0;
      alu_b    = 16'h3C3C;
      @(posedge clk);
      #1;
      alu_func = 4'h0;
      alu_a    = 16'h1111;
      alu_b    = 16'h2222;
      @(posedge clk);
      #1;
      chk("bp.enter_done", 32'(out_valid), 32'h1);
      held = alu_out;
      chk("bp.result", 32'(held), 32'h3030);
      for (int i = 0; i < 5; i++) begin
         @(posedge clk);
         #1;
         chk("bp.hold", 32'({out_valid, in_ready, alu_out}), 32'({2'b10, 16'h3030}));
      end
      @(negedge clk);
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      chk("bp.release", 32'({in_ready, out_valid}), 32'(2'b10));
      seen = 1'b0;
      repeat (4) begin
         @(posedge clk);
         #1;
         seen = seen | out_valid;
      end
      chk("bp.no_second_op", 32'(seen), 32'h0);

      // Reset during MUL discards the operation.
      @(negedge clk);
      in_valid = 1'b1;
      alu_func = 4'h9;
      alu_a    = 16'h1234;
      alu_b    = 16'h00FF;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      repeat (5) @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      #1;
      chk("rst_mul.state", 32'({in_ready, out_valid, c, z, v, s}), 32'(6'b100000));
      chk("rst_mul.alu_out", 32'(alu_out), 32'h0);
      @(negedge clk);
      reset = 1'b0;
      seen  = 1'b0;
      repeat (25) begin
         @(posedge clk);
         #1;
         seen = seen | out_valid;
      end
      chk("rst_mul.no_result", 32'(seen), 32'h0);

      for (int i = 0; i < 60; i++) begin
         do_op("rand", 4'($urandom_range(0, 15)), W'($urandom), W'($urandom), 1'($urandom));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
